pc_next_unit: RTL and testbench

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/pc_next_if.sv | 32 +++
 rtl/pc_next_unit.sv | 88 ++++++++
 tb/tb_pc_next_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_next_if.sv
// pc_next_if: bus between the PC next-address unit and its driver.
//   master : drives pc_source, src, pc_write, stall, exc_req; observes PC state.
//   slave  : the PC unit; consumes the requests, drives pc, pc_plus4, epc,
//            misalign and pend_valid.
`timescale 1ns/1ps
interface pc_next_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4
);
    localparam int SW = $clog2(NSRC);

    logic [SW-1:0]         pc_source;
    logic [NSRC*WIDTH-1:0] src;
    logic                  pc_write;
    logic                  stall;
    logic                  exc_req;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      pc_plus4;
    logic [WIDTH-1:0]      epc;
    logic                  misalign;
    logic                  pend_valid;

    modport master (
        output pc_source, src, pc_write, stall, exc_req,
        input  pc, pc_plus4, epc, misalign, pend_valid
    );

    modport slave (
        input  pc_source, src, pc_write, stall, exc_req,
        output pc, pc_plus4, epc, misalign, pend_valid
    );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: program counter with prioritized next-PC selection.
//   clk   : single clock, rising edge.
//   reset : asynchronous active-high reset.
//   bus   : pc_next_if slave modport
//     pc_source/src : source channel select and flattened source targets
//     pc_write      : load the selected target
//     stall         : hold pc; a redirect requested during a stall is parked
//                     in a one-entry pending buffer (latest wins)
//     exc_req       : exception, highest priority; pc <= EXC_VEC, epc <= pc
//     pc, pc_plus4, epc, misalign, pend_valid : PC state outputs
// Edge priority: exception, stall, load (new request, else pending), hold.
// Misaligned loads redirect to EXC_VEC and pulse misalign for one cycle.
`timescale 1ns/1ps
module pc_next_unit #(
    parameter int               WIDTH    = 32,
    parameter int               NSRC     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_0180)
) (
    input  logic      clk,
    input  logic      reset,
    pc_next_if.slave  bus
);
    localparam int SW = $clog2(NSRC);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_valid;
    logic             r_misalign;

    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] w_load_val;
    logic             w_do_load;

    // Source mux; a select with no matching channel (non power-of-two NSRC)
    // falls back to channel 0.
    always_comb begin
        w_tgt = bus.src[WIDTH-1:0];
        for (int i = 1; i < NSRC; i++) begin
            if (bus.pc_source == SW'(i))
                w_tgt = bus.src[i*WIDTH +: WIDTH];
        end
    end

    // A fresh request beats the parked one.
    assign w_load_val = bus.pc_write ? w_tgt : r_pend;
    assign w_do_load  = !bus.exc_req && !bus.stall && (bus.pc_write || r_pend_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_epc        <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (bus.exc_req) begin
                r_pc         <= EXC_VEC;
                r_epc        <= r_pc;
                r_pend_valid <= 1'b0;
            end else if (bus.stall) begin
                // Alignment is not checked at capture, only when the entry loads.
                if (bus.pc_write) begin
                    r_pend       <= w_tgt;
                    r_pend_valid <= 1'b1;
                end
            end else if (w_do_load) begin
                r_pend_valid <= 1'b0;
                if (w_load_val[1:0] == 2'b00) begin
                    r_pc <= w_load_val;
                end else begin
                    r_pc       <= EXC_VEC;
                    r_epc      <= r_pc;
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign bus.pc         = r_pc;
    assign bus.pc_plus4   = r_pc + WIDTH'(4);
    assign bus.epc        = r_epc;
    assign bus.misalign   = r_misalign;
    assign bus.pend_valid = r_pend_valid;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: scenario tasks drive one cycle at a time; each cycle's
// expected PC state is pushed to a scoreboard queue when the stimulus is
// driven and popped/compared after the clock edge.
`timescale 1ns/1ps
module tb_pc_next_unit;
    localparam int WIDTH = 32;
    localparam int NSRC  = 4;

    typedef struct {
        int          sel;
        logic [31:0] val;
        bit          wr;
        bit          st;
        bit          ex;
        logic [31:0] pc;
        logic [31:0] epc;
        bit          mis;
        bit          pv;
    } step_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    step_t q[$];

    pc_next_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bus ();

    pc_next_unit #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input step_t s);
        bus.pc_source = 2'(s.sel);
        bus.src[s.sel*WIDTH +: WIDTH] = s.val;
        bus.pc_write  = s.wr;
        bus.stall     = s.st;
        bus.exc_req   = s.ex;
        q.push_back(s);
    endtask

    task automatic test_reset();
        step_t s[1];
        step_t e;
        #2;
        n_chk++;
        if (bus.pc !== 32'h0 || bus.epc !== 32'h0 || bus.pend_valid !== 1'b0 ||
            bus.misalign !== 1'b0 || bus.pc_plus4 !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_async: pc=%h epc=%h pv=%b mis=%b p4=%h, want 0/0/0/0/4",
                     bus.pc, bus.epc, bus.pend_valid, bus.misalign, bus.pc_plus4);
        end
        @(negedge clk);
        reset = 1'b0;
        s[0] = '{0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 1; i++) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_chk++;
            if (bus.pc !== e.pc || bus.epc !== e.epc || bus.misalign !== e.mis ||
                bus.pend_valid !== e.pv || bus.pc_plus4 !== e.pc + 32'd4) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: pc=%h epc=%h mis=%b pv=%b, want %h %h %b %b",
                         i, bus.pc, bus.epc, bus.misalign, bus.pend_valid, e.pc, e.epc, e.mis, e.pv);
            end
        end
    endtask

    task automatic test_load();
        step_t s[1];
        step_t e;
        s[0] = '{2, 32'h40, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 1; i++) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_chk++;
            if (bus.pc !== e.pc || bus.epc !== e.epc || bus.misalign !== e.mis ||
                bus.pend_valid !== e.pv || bus.pc_plus4 !== e.pc + 32'd4) begin
                n_fail++;
                $display("FAIL load[%0d]: pc=%h epc=%h mis=%b pv=%b, want %h %h %b %b",
                         i, bus.pc, bus.epc, bus.misalign, bus.pend_valid, e.pc, e.epc, e.mis, e.pv);
            end
        end
    endtask

    task automatic test_stall_capture();
        step_t s[5];
        step_t e;
        s[0] = '{1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h40,  32'h0, 1'b0, 1'b1};
        s[1] = '{3, 32'h200, 1'b1, 1'b1, 1'b0, 32'h40,  32'h0, 1'b0, 1'b1};
        s[2] = '{0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h40,  32'h0, 1'b0, 1'b1};
        s[3] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0};
        s[4] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_chk++;
            if (bus.pc !== e.pc || bus.epc !== e.epc || bus.misalign !== e.mis ||
                bus.pend_valid !== e.pv || bus.pc_plus4 !== e.pc + 32'd4) begin
                n_fail++;
                $display("FAIL stall_capture[%0d]: pc=%h epc=%h mis=%b pv=%b, want %h %h %b %b",
                         i, bus.pc, bus.epc, bus.misalign, bus.pend_valid, e.pc, e.epc, e.mis, e.pv);
            end
        end
    endtask

    task automatic test_misalign();
        step_t s[6];
        step_t e;
        s[0] = '{2, 32'h40,  1'b1, 1'b0, 1'b0, 32'h40,  32'h0,   1'b0, 1'b0};
        s[1] = '{2, 32'h42,  1'b1, 1'b0, 1'b0, 32'h180, 32'h40,  1'b1, 1'b0};
        s[2] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h180, 32'h40,  1'b0, 1'b0};
        // misaligned value parks without complaint, faults when it loads
        s[3] = '{1, 32'h103, 1'b1, 1'b1, 1'b0, 32'h180, 32'h40,  1'b0, 1'b1};
        s[4] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h180, 32'h180, 1'b1, 1'b0};
        s[5] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h180, 32'h180, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_chk++;
            if (bus.pc !== e.pc || bus.epc !== e.epc || bus.misalign !== e.mis ||
                bus.pend_valid !== e.pv || bus.pc_plus4 !== e.pc + 32'd4) begin
                n_fail++;
                $display("FAIL misalign[%0d]: pc=%h epc=%h mis=%b pv=%b, want %h %h %b %b",
                         i, bus.pc, bus.epc, bus.misalign, bus.pend_valid, e.pc, e.epc, e.mis, e.pv);
            end
        end
    endtask

    task automatic test_exception();
        step_t s[4];
        step_t e;
        s[0] = '{3, 32'h200, 1'b1, 1'b0, 1'b0, 32'h200, 32'h180, 1'b0, 1'b0};
        s[1] = '{1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h200, 32'h180, 1'b0, 1'b1};
        s[2] = '{2, 32'h40,  1'b1, 1'b1, 1'b1, 32'h180, 32'h200, 1'b0, 1'b0};
        s[3] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h180, 32'h200, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_chk++;
            if (bus.pc !== e.pc || bus.epc !== e.epc || bus.misalign !== e.mis ||
                bus.pend_valid !== e.pv || bus.pc_plus4 !== e.pc + 32'd4) begin
                n_fail++;
                $display("FAIL exception[%0d]: pc=%h epc=%h mis=%b pv=%b, want %h %h %b %b",
                         i, bus.pc, bus.epc, bus.misalign, bus.pend_valid, e.pc, e.epc, e.mis, e.pv);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[5];
        step_t e;
        s[0] = '{1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h180, 32'h200, 1'b0, 1'b1};
        s[1] = '{3, 32'h300, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b0, 1'b0};
        s[2] = '{2, 32'h44,  1'b1, 1'b0, 1'b0, 32'h44,  32'h200, 1'b0, 1'b0};
        s[3] = '{1, 32'h48,  1'b1, 1'b0, 1'b0, 32'h48,  32'h200, 1'b0, 1'b0};
        s[4] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h48,  32'h200, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_chk++;
            if (bus.pc !== e.pc || bus.epc !== e.epc || bus.misalign !== e.mis ||
                bus.pend_valid !== e.pv || bus.pc_plus4 !== e.pc + 32'd4) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: pc=%h epc=%h mis=%b pv=%b, want %h %h %b %b",
                         i, bus.pc, bus.epc, bus.misalign, bus.pend_valid, e.pc, e.epc, e.mis, e.pv);
            end
        end
    endtask

    task automatic test_wrap();
        step_t s[2];
        step_t e;
        s[0] = '{2, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h200, 1'b0, 1'b0};
        s[1] = '{0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h200, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_chk++;
            if (bus.pc !== e.pc || bus.epc !== e.epc || bus.misalign !== e.mis ||
                bus.pend_valid !== e.pv || bus.pc_plus4 !== 32'h0) begin
                n_fail++;
                $display("FAIL wrap[%0d]: pc=%h p4=%h epc=%h mis=%b pv=%b, want %h 0 %h %b %b",
                         i, bus.pc, bus.pc_plus4, bus.epc, bus.misalign, bus.pend_valid,
                         e.pc, e.epc, e.mis, e.pv);
            end
        end
    endtask

    task automatic test_reset_pending();
        step_t s[3];
        step_t e;
        s[0] = '{1, 32'h100, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h200, 1'b0, 1'b1};
        s[1] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0};
        s[2] = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = q.pop_front();
            n_chk++;
            if (bus.pc !== e.pc || bus.epc !== e.epc || bus.misalign !== e.mis ||
                bus.pend_valid !== e.pv || bus.pc_plus4 !== e.pc + 32'd4) begin
                n_fail++;
                $display("FAIL reset_pending[%0d]: pc=%h epc=%h mis=%b pv=%b, want %h %h %b %b",
                         i, bus.pc, bus.epc, bus.misalign, bus.pend_valid, e.pc, e.epc, e.mis, e.pv);
            end
            if (i == 0) begin
                // mid-cycle reset pulse: takes effect with no clock edge
                #3 reset = 1'b1;
                #1;
                n_chk++;
                if (bus.pc !== 32'h0 || bus.pend_valid !== 1'b0 || bus.epc !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_async_mid: pc=%h pv=%b epc=%h, want 0 0 0",
                             bus.pc, bus.pend_valid, bus.epc);
                end
                #1 reset = 1'b0;
            end
        end
    endtask

    initial begin
        clk           = 1'b0;
        reset         = 1'b1;
        n_chk         = 0;
        n_fail        = 0;
        bus.pc_source = '0;
        bus.src       = '0;
        bus.pc_write  = 1'b0;
        bus.stall     = 1'b0;
        bus.exc_req   = 1'b0;
        test_reset();
        test_load();
        test_stall_capture();
        test_misalign();
        test_exception();
        test_back_to_back();
        test_wrap();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: run exceeded 20000 ns");
        $fatal(1);
    end
endmodule
